// File: rtl/compressed_line_packer_if.sv
// Word-in / line-out handshake bundle between the length accumulator,
// the line packer and the line writer.
interface compressed_line_packer_if #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 64,
  parameter int LEN_W      = 7
);
  logic                  i_valid;
  logic                  o_ready;
  logic [WORD_SIZE-1:0]  i_data;
  logic [LEN_W-1:0]      i_length;
  logic                  i_last;
  logic [CACHE_LINE-1:0] o_line;
  logic [7:0]            o_line_len;
  logic                  o_overflow;
  logic                  o_line_valid;
  logic                  i_line_ready;

  // packer side
  modport slave (
    input  i_valid, i_data, i_length, i_last, i_line_ready,
    output o_ready, o_line, o_line_len, o_overflow, o_line_valid
  );

  // upstream word source / downstream line writer side
  modport master (
    output i_valid, i_data, i_length, i_last, i_line_ready,
    input  o_ready, o_line, o_line_len, o_overflow, o_line_valid
  );
endinterface

// File: rtl/compressed_line_packer.sv
// Packs variable-length LSB-aligned compressed words LSB-first into one
// cache line and hands it to the line writer with a valid/ready handshake.
module compressed_line_packer #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 64,
  parameter int LEN_W      = 7
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  compressed_line_packer_if.slave  bus
);
  localparam int FILL_W = 8;

  typedef enum logic [0:0] {ACCUM, EMIT} state_t;

  state_t                state_reg;
  logic [CACHE_LINE-1:0] buffer_reg;
  logic [FILL_W-1:0]     fill_reg;
  logic                  overflow_reg;
  logic                  ready_reg;
  logic                  line_valid_reg;
  logic [CACHE_LINE-1:0] line_reg;
  logic [FILL_W-1:0]     line_len_reg;
  logic                  line_overflow_reg;

  logic                  len_illegal;
  logic [LEN_W-1:0]      len_eff;
  logic [WORD_SIZE-1:0]  word_mask;
  logic [WORD_SIZE-1:0]  word_masked;
  logic [FILL_W-1:0]     sum_next;
  logic                  word_fits;
  logic [CACHE_LINE-1:0] buffer_next;
  logic [FILL_W-1:0]     fill_next;
  logic                  overflow_next;
  logic                  accept;

  // Out-of-range lengths are clamped and always force the overflow path.
  assign len_illegal = bus.i_length > LEN_W'(WORD_SIZE);
  assign len_eff     = len_illegal ? LEN_W'(WORD_SIZE) : bus.i_length;

  generate
    for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_mask
      assign word_mask[gi] = (32'(len_eff) > gi);
    end
  endgenerate

  assign word_masked = bus.i_data & word_mask;
  assign sum_next    = fill_reg + FILL_W'(len_eff);
  assign word_fits   = !overflow_reg && !len_illegal &&
                       (sum_next <= FILL_W'(CACHE_LINE));

  assign buffer_next   = word_fits ? (buffer_reg | (CACHE_LINE'(word_masked) << fill_reg))
                                   : buffer_reg;
  assign fill_next     = word_fits ? sum_next : fill_reg;
  assign overflow_next = overflow_reg | !word_fits;

  assign accept = bus.i_valid && ready_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg         <= ACCUM;
      buffer_reg        <= '0;
      fill_reg          <= '0;
      overflow_reg      <= 1'b0;
      ready_reg         <= 1'b1;
      line_valid_reg    <= 1'b0;
      line_reg          <= '0;
      line_len_reg      <= '0;
      line_overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (bus.i_last) begin
              // Line moves to the output registers, so the accumulator can
              // be cleared now; it is not used again until the line is taken.
              state_reg         <= EMIT;
              ready_reg         <= 1'b0;
              line_valid_reg    <= 1'b1;
              line_reg          <= buffer_next;
              line_len_reg      <= fill_next;
              line_overflow_reg <= overflow_next;
              buffer_reg        <= '0;
              fill_reg          <= '0;
              overflow_reg      <= 1'b0;
            end else begin
              buffer_reg   <= buffer_next;
              fill_reg     <= fill_next;
              overflow_reg <= overflow_next;
            end
          end
        end
        EMIT: begin
          if (bus.i_line_ready) begin
            state_reg      <= ACCUM;
            ready_reg      <= 1'b1;
            line_valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.o_ready      = ready_reg;
  assign bus.o_line_valid = line_valid_reg;
  assign bus.o_line       = line_reg;
  assign bus.o_line_len   = line_len_reg;
  assign bus.o_overflow   = line_overflow_reg;
endmodule

// File: tb/tb_compressed_line_packer.sv
// Bench for compressed_line_packer: directed scenarios plus random lines,
// checked every cycle against a word-queue reference model.
module tb_compressed_line_packer;
  localparam int CL = 128;
  localparam int WS = 64;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compressed_line_packer_if #(.CACHE_LINE(CL), .WORD_SIZE(WS), .LEN_W(LW)) pif ();

  compressed_line_packer #(.CACHE_LINE(CL), .WORD_SIZE(WS), .LEN_W(LW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (pif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [CL-1:0] act, logic [CL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: words of the open line are queued; the line is built
  // from the queue when the last word arrives.
  bit            m_valid;
  logic [CL-1:0] m_line;
  int            m_len;
  bit            m_ovf;
  logic [WS-1:0] q_data[$];
  int            q_len[$];

  function automatic logic [WS-1:0] len_mask(int len);
    logic [WS-1:0] m;
    if (len >= WS) m = '1;
    else m = (64'd1 << len) - 64'd1;
    return m;
  endfunction

  task automatic build_line();
    int pos = 0;
    bit ovf = 0;
    logic [CL-1:0] ln = '0;
    for (int i = 0; i < q_len.size(); i++) begin
      if (!ovf && pos + q_len[i] <= CL) begin
        ln  = ln | ({64'b0, q_data[i]} << pos);
        pos = pos + q_len[i];
      end else begin
        ovf = 1;
      end
    end
    m_line = ln;
    m_len  = pos;
    m_ovf  = ovf;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0;
      q_data.delete();
      q_len.delete();
    end else if (m_valid) begin
      if (pif.i_line_ready) m_valid = 0;
    end else if (pif.i_valid) begin
      q_data.push_back(pif.i_data & len_mask(int'(pif.i_length)));
      q_len.push_back(int'(pif.i_length));
      if (pif.i_last) begin
        build_line();
        m_valid = 1;
        q_data.delete();
        q_len.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", CL'(pif.o_ready), CL'(!m_valid));
      chk("line_valid", CL'(pif.o_line_valid), CL'(m_valid));
      if (m_valid) begin
        chk("line", pif.o_line, m_line);
        chk("line_len", CL'(pif.o_line_len), CL'(m_len));
        chk("overflow", CL'(pif.o_overflow), CL'(m_ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(logic [WS-1:0] d, int len, bit last, int gap);
    bit done = 0;
    for (int g = 0; g < gap; g++) begin
      pif.i_line_ready = 1'($urandom % 2);
      step();
    end
    pif.i_line_ready = 1'b0;
    pif.i_valid  = 1'b1;
    pif.i_data   = d;
    pif.i_length = LW'(len);
    pif.i_last   = last;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = !m_valid;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", CL'(done), CL'(1));
    pif.i_valid  = 1'b0;
    pif.i_last   = 1'b0;
    pif.i_data   = {$urandom, $urandom};
    pif.i_length = LW'($urandom_range(0, WS));
  endtask

  task automatic lit_line(string name, logic [CL-1:0] ln, int len, bit ovf);
    chk({name, "_valid"}, CL'(pif.o_line_valid), CL'(1));
    chk({name, "_line"}, pif.o_line, ln);
    chk({name, "_len"}, CL'(pif.o_line_len), CL'(len));
    chk({name, "_ovf"}, CL'(pif.o_overflow), CL'(ovf));
  endtask

  // Hold the line for 'hold' cycles (optionally with a stray word offered),
  // then take it; the stray word is still offered during the handshake.
  task automatic take_line(int hold, bit junk);
    chk("line_pending", CL'(m_valid), CL'(1));
    pif.i_line_ready = 1'b0;
    if (junk) begin
      pif.i_valid  = 1'b1;
      pif.i_length = LW'(8);
      pif.i_last   = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_ready_low", CL'(pif.o_ready), CL'(0));
    end
    pif.i_line_ready = 1'b1;
    step();
    pif.i_line_ready = 1'b0;
    pif.i_valid = 1'b0;
    pif.i_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_ready"}, CL'(pif.o_ready), CL'(1));
    chk({name, "_valid"}, CL'(pif.o_line_valid), CL'(0));
    chk({name, "_line"}, pif.o_line, '0);
    chk({name, "_len"}, CL'(pif.o_line_len), CL'(0));
    chk({name, "_ovf"}, CL'(pif.o_overflow), CL'(0));
  endtask

  task automatic apply_reset();
    pif.i_valid = 1'b0;
    pif.i_last  = 1'b0;
    pif.i_line_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    pif.i_valid = 1'b0;
    pif.i_data = '0;
    pif.i_length = '0;
    pif.i_last = 1'b0;
    pif.i_line_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: exact full line from 40+24+64 bits
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 40, 0, 0);
    send_word(64'h5555_5555_5555_5555, 24, 0, 1);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 64, 1, 0);
    lit_line("t1", {64'hFFFF_FFFF_FFFF_FFFF, 24'h55_5555, 40'hAA_AAAA_AAAA}, 128, 0);
    take_line(0, 0);

    // 2: junk above the length bits must be masked, upper line zero
    send_word(64'hFFFF_FFFF_FFF1_2345, 20, 0, 0);
    send_word(64'hFFFF_FFFF_3ABC_DEF0, 30, 1, 0);
    lit_line("t2", 128'h3_ABCD_EF01_2345, 50, 0);
    take_line(0, 0);

    // 3 + 4: overflow drops the third word; line held 5 cycles with a stray word
    send_word(64'h0123_4567_89AB_CDEF, 64, 0, 0);
    send_word(64'hFEDC_BA98_7654_3210, 64, 0, 0);
    send_word(64'h0000_0000_0000_00FF, 8, 1, 0);
    lit_line("t3", {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 128, 1);
    take_line(5, 1);

    // 5: zero-length single word
    send_word(64'hDEAD_BEEF_0000_0000, 0, 1, 0);
    lit_line("t5", '0, 0, 0);
    take_line(0, 0);

    // full line followed by a zero-length last word is not an overflow
    send_word(64'h1111_2222_3333_4444, 64, 0, 0);
    send_word(64'h5555_6666_7777_8888, 64, 0, 0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    lit_line("full0", {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444}, 128, 0);
    take_line(1, 0);

    // 6: reset mid-line, then mid-EMIT
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 33, 0, 0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 17, 0, 0);
    apply_reset();
    send_word(64'h3, 2, 0, 0);
    send_word(64'h1, 1, 1, 0);
    lit_line("t6a", 128'h7, 3, 0);
    take_line(0, 0);
    send_word(64'hF, 4, 1, 0);
    apply_reset();
    send_word(64'hD, 3, 1, 0);
    lit_line("t6b", 128'h5, 3, 0);
    take_line(0, 0);

    // random lines
    for (int l = 0; l < 150; l++) begin
      int nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        int r = $urandom % 8;
        int len = (r == 0) ? 0 : (r == 1) ? WS : $urandom_range(1, WS);
        send_word({$urandom, $urandom}, len, (w == nw - 1), $urandom % 3);
      end
      take_line($urandom % 4, 1'($urandom % 2));
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
